// File: rtl/usb_fs_in_ep_fifo.sv
// -----------------------------------------------------------------------------
// usb_fs_in_ep_fifo
//
// Application-side IN endpoint buffer. The application pushes bytes into a
// local FIFO. The FIFO contents are then cut into USB full-speed IN packets of
// at most MAX_PKT bytes. For each packet the block requests the IN endpoint
// arbiter, moves the bytes into the protocol engine's packet buffer while it
// is granted, strobes end-of-packet, and then waits for the host ACK.
// A flush request from the application ends the current transfer. It does so
// with either a short packet or a zero-length packet (ZLP).
//
// Ports
//   clk              48 MHz clock
//   reset_n          asynchronous active-low reset
//   app_data         byte to enqueue
//   app_valid        app_data is valid
//   app_ready        FIFO has room
//   app_flush        one-cycle pulse: end the transfer (short packet / ZLP)
//   in_ep_req        request to the arbiter
//   in_ep_grant      grant from the arbiter
//   in_ep_data_free  protocol engine buffer can take a byte
//   in_ep_data_put   byte transfer strobe
//   in_ep_data       byte being put (FIFO head, combinational)
//   in_ep_data_done  one-cycle end-of-packet strobe
//   in_ep_acked      one-cycle pulse: host ACKed the last packet
//   busy             packet engine is not idle
//   state_dbg        current FSM state, for debug and checkers
//
// Handshakes: a byte moves from the application into the FIFO on a clock edge
// where app_valid && app_ready are both high. app_valid may be asserted
// without regard to app_ready. app_ready does not depend on app_valid. A byte
// moves out to the protocol engine on an edge where in_ep_data_put is high.
// in_ep_data_put is only raised while in_ep_grant && in_ep_data_free are both
// high.
// -----------------------------------------------------------------------------
module usb_fs_in_ep_fifo #(
  parameter int MAX_PKT    = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] app_data,
  input  logic       app_valid,
  output logic       app_ready,
  input  logic       app_flush,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  input  logic       in_ep_acked,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(MAX_PKT) + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_PKT_C = CW'(MAX_PKT);
  localparam logic [RW-1:0] MAX_PKT_R = RW'(MAX_PKT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_DONE     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic          pkt_short_q, pkt_short_d;
  logic          flush_pending_q, flush_pending_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic push, pop;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign app_ready  = (count < DEPTH_C);
  assign push       = app_valid && app_ready;
  assign pop        = in_ep_data_put;
  assign in_ep_data = mem[rd_ptr];

  // The storage array has no reset. Its contents are only read behind count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= app_data;
    end
  end

  // AW-bit pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      pkt_short_q     <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      pkt_short_q     <= pkt_short_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pkt_short_d = pkt_short_q;

    unique case (state_q)
      S_IDLE: begin
        // The packet length is fixed here. Bytes that arrive later belong to
        // the next packet.
        if (count >= MAX_PKT_C) begin
          remaining_d = MAX_PKT_R;
          pkt_short_d = 1'b0;
          state_d     = S_FILL;
        end else if (flush_pending_q) begin
          // count < MAX_PKT here, so it fits in RW bits. 0 gives a ZLP.
          remaining_d = count[RW-1:0];
          pkt_short_d = 1'b1;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (in_ep_data_put) begin
          remaining_d = remaining_q - RW'(1);
          if (remaining_q == RW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (in_ep_grant) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (in_ep_acked) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new flush request wins over the clear that a terminating packet
  // performs in the same cycle.
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (in_ep_data_done && pkt_short_q) flush_pending_d = 1'b0;
    if (app_flush)                      flush_pending_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ep_req       = 1'b0;
    in_ep_data_put  = 1'b0;
    in_ep_data_done = 1'b0;
    unique case (state_q)
      S_FILL: begin
        in_ep_req      = 1'b1;
        in_ep_data_put = (remaining_q != '0) && in_ep_grant && in_ep_data_free;
      end
      S_DONE: begin
        in_ep_req       = 1'b1;
        in_ep_data_done = in_ep_grant;
      end
      default: begin
        in_ep_req = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_usb_fs_in_ep_fifo.sv
// -----------------------------------------------------------------------------
// tb_usb_fs_in_ep_fifo
//
// Stimulus writes bytes and flush pulses. Every accepted byte is pushed into
// exp_q. The expected packet lengths for each transfer are computed from the
// packetization rules: full MAX_PKT packets first, then the remainder if a
// flush is pending (0 gives a ZLP). These lengths go into exp_len_q.
// A monitor compares every put and every done against these queues.
// -----------------------------------------------------------------------------
module tb_usb_fs_in_ep_fifo;

  localparam int MAX_PKT    = 64;
  localparam int FIFO_DEPTH = 128;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] app_data;
  logic       app_valid;
  logic       app_ready;
  logic       app_flush;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_acked;
  logic       busy;
  logic [1:0] state_dbg;

  always #10 clk = ~clk;

  usb_fs_in_ep_fifo #(.MAX_PKT(MAX_PKT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .app_data        (app_data),
    .app_valid       (app_valid),
    .app_ready       (app_ready),
    .app_flush       (app_flush),
    .in_ep_req       (in_ep_req),
    .in_ep_grant     (in_ep_grant),
    .in_ep_data_free (in_ep_data_free),
    .in_ep_data_put  (in_ep_data_put),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_ep_acked     (in_ep_acked),
    .busy            (busy),
    .state_dbg       (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  int         total = 0;
  int         bad = 0;
  int         total_puts = 0;
  int         gmode = 1;   // 0: grant/free low, 1: both high, 2: random

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference packetization: full packets first, then the remainder only when
  // the transfer is flushed.
  task automatic plan_transfer(input int nbytes, input bit flushed);
    for (int i = 0; i < nbytes / MAX_PKT; i++) exp_len_q.push_back(MAX_PKT);
    if (flushed) exp_len_q.push_back(nbytes % MAX_PKT);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called right after a posedge)
  // ---------------------------------------------------------------------------
  task automatic write_byte(input logic [7:0] b, input int max_wait, output bit ok);
    ok        = 1'b0;
    app_data  = b;
    app_valid = 1'b1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (app_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    app_valid = 1'b0;
    if (ok) exp_q.push_back(b);
  endtask

  task automatic write_seq(input logic [7:0] first, input int n, input bit rnd);
    bit ok;
    for (int i = 0; i < n; i++) begin
      write_byte(rnd ? 8'($urandom_range(0, 255)) : 8'(first + 8'(i)), 200, ok);
      if (!ok) check("write_accept", 0, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_flush();
    app_flush = 1'b1;
    @(posedge clk);
    #1;
    app_flush = 1'b0;
  endtask

  // Wait until every planned packet has been sent and acked.
  task automatic wait_idle(input string name);
    bit drained = 1'b0;
    int reqs = 0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      @(negedge clk);
      if (exp_len_q.size() == 0 && !busy) drained = 1'b1;
    end
    check({name, "_drain"}, int'(drained), 1);
    check({name, "_leftover_bytes"}, exp_q.size(), 0);
    repeat (20) begin
      @(negedge clk);
      if (in_ep_req || busy) reqs++;
    end
    check({name, "_no_extra_req"}, reqs, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Arbiter / engine model: grant and data_free
  // ---------------------------------------------------------------------------
  initial begin
    in_ep_grant     = 1'b0;
    in_ep_data_free = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gmode)
        0: begin in_ep_grant = 1'b0; in_ep_data_free = 1'b0; end
        1: begin in_ep_grant = 1'b1; in_ep_data_free = 1'b1; end
        default: begin
          in_ep_grant     = 1'($urandom_range(0, 1));
          in_ep_data_free = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Host model: ACK five cycles after each end-of-packet strobe.
  initial begin
    in_ep_acked = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && in_ep_data_done) begin
        repeat (5) @(posedge clk);
        #1;
        in_ep_acked = 1'b1;
        @(posedge clk);
        #1;
        in_ep_acked = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops and compares whenever the DUT presents a put or a done
  // ---------------------------------------------------------------------------
  initial begin
    int pkt_puts = 0;
    bit waiting = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pkt_puts = 0;
        waiting  = 1'b0;
      end else begin
        if (waiting) begin
          check("req_low_in_wait_ack", int'(in_ep_req), 0);
          if (in_ep_acked) waiting = 1'b0;
        end
        if (in_ep_data_put) begin
          check("put_gated", int'(in_ep_grant && in_ep_data_free), 1);
          if (exp_q.size() == 0) check("put_underflow", 1, 0);
          else check("put_data", int'(in_ep_data), int'(exp_q.pop_front()));
          pkt_puts++;
          total_puts++;
          if (pkt_puts > MAX_PKT) check("puts_per_packet", pkt_puts, MAX_PKT);
        end
        if (in_ep_data_done) begin
          if (exp_len_q.size() == 0) check("unexpected_done", 1, 0);
          else check("pkt_len", pkt_puts, exp_len_q.pop_front());
          pkt_puts = 0;
          waiting  = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    int accepted;
    int base;
    bit reached;

    reset_n   = 1'b0;
    app_data  = 8'h00;
    app_valid = 1'b0;
    app_flush = 1'b0;
    gmode     = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", int'(in_ep_req), 0);
    check("rst_put", int'(in_ep_data_put), 0);
    check("rst_done", int'(in_ep_data_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_app_ready", int'(app_ready), 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: one full packet 0x00..0x3F.
    plan_transfer(64, 1'b0);
    write_seq(8'h00, 64, 1'b0);
    wait_idle("full_pkt");

    // 2: short packet 0xA0..0xA9 terminated by flush.
    plan_transfer(10, 1'b1);
    write_seq(8'hA0, 10, 1'b0);
    pulse_flush();
    wait_idle("short_pkt");

    // 3: full packet followed by flush -> full packet then ZLP.
    plan_transfer(64, 1'b1);
    write_seq(8'h00, 64, 1'b1);
    pulse_flush();
    wait_idle("full_then_zlp");

    // 4: flush with an empty FIFO -> single ZLP.
    plan_transfer(0, 1'b1);
    pulse_flush();
    wait_idle("zlp_only");

    // 5: fill the FIFO with no grant, then drain with random grant/free.
    gmode    = 0;
    accepted = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 130; i++) begin
      write_byte(8'($urandom_range(0, 255)), 1, ok);
      if (ok) accepted++;
    end
    @(negedge clk);
    check("fill_accepted", accepted, FIFO_DEPTH);
    check("fill_app_ready_low", int'(app_ready), 0);
    check("fill_no_puts_without_grant", exp_q.size(), FIFO_DEPTH);
    plan_transfer(FIFO_DEPTH, 1'b0);
    @(posedge clk);
    #1;
    gmode = 2;
    wait_idle("random_grant");
    gmode = 1;

    // 6: asynchronous reset mid-FILL after 20 puts.
    plan_transfer(64, 1'b0);
    write_seq(8'h00, 64, 1'b1);
    base    = total_puts;
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (total_puts >= base + 20) reached = 1'b1;
    end
    check("mid_fill_reached", int'(reached), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", int'(in_ep_req), 0);
    check("arst_put", int'(in_ep_data_put), 0);
    check("arst_done", int'(in_ep_data_done), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_app_ready", int'(app_ready), 1);
    exp_q.delete();
    exp_len_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    plan_transfer(64, 1'b0);
    write_seq(8'h00, 64, 1'b1);
    wait_idle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_fs_in_ep_fifo.md
Name: usb_fs_in_ep_fifo

Overview:
Application-side IN endpoint buffer that sits directly upstream of the IN endpoint arbiter and the IN protocol engine. It accepts a byte stream from application logic into a local FIFO and splits it into USB full-speed IN packets of at most MAX_PKT bytes. It requests the arbiter, pushes bytes into the protocol engine's packet buffer while granted, marks packet end, and then waits for the host ACK. Short-packet and zero-length-packet (ZLP) termination are driven by an application flush request.

Parameters:
MAX_PKT, 64, max packet size in bytes; legal values 8/16/32/64
FIFO_DEPTH, 128, local FIFO depth in bytes; power of 2, >= MAX_PKT

Ports:
clk  input  1  sole clock, 48 MHz domain
reset_n  input  1  asynchronous active-low reset
app_data  input  8  byte to enqueue
app_valid  input  1  app_data valid
app_ready  output  1  FIFO can accept; write occurs when app_valid && app_ready
app_flush  input  1  one-cycle pulse: terminate the current transfer (short packet or ZLP)
in_ep_req  output  1  request to arbiter
in_ep_grant  input  1  grant from arbiter
in_ep_data_free  input  1  protocol engine buffer can take a byte
in_ep_data_put  output  1  byte transfer strobe
in_ep_data  output  8  byte being put (FIFO head)
in_ep_data_done  output  1  one-cycle end-of-packet strobe
in_ep_acked  input  1  one-cycle pulse: host ACKed last packet
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE, FIFO pointers and count = 0, flush_pending = 0. Outputs in_ep_req = 0, in_ep_data_put = 0, in_ep_data_done = 0, busy = 0, app_ready = 1, in_ep_data = mem[rd_ptr] (value don't-care). Reset mid-packet discards FIFO contents and the partial packet. No further strobes are issued for that packet.
- FIFO: count has width clog2(FIFO_DEPTH)+1. app_ready = (count < FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave count unchanged. in_ep_data is combinational from mem[rd_ptr], so zero latency from pop to next byte.
- flush_pending: set by app_flush (set wins over clear in the same cycle). Cleared on the cycle data_done is issued for a packet whose length < MAX_PKT, including a ZLP.
- State machine (IDLE, FILL, DONE, WAIT_ACK):
  - IDLE: in_ep_req = 0.
    - If count >= MAX_PKT: remaining := MAX_PKT, pkt_short := 0, go to FILL.
    - Else if flush_pending: remaining := count (0 gives a ZLP), pkt_short := 1, go to FILL.
    - Else stay in IDLE.
    - The length is captured on entry. Bytes written later belong to the next packet.
  - FILL: in_ep_req = 1.
    - If remaining == 0: go to DONE.
    - Else in_ep_data_put = in_ep_grant && in_ep_data_free. On put: pop the FIFO and decrement remaining. Go to DONE on the cycle remaining becomes 0.
    - Loss of grant or data_free pauses the transfer with no put; req is held.
  - DONE: in_ep_req = 1. When in_ep_grant: in_ep_data_done = 1 for exactly one cycle, clear flush_pending if pkt_short, go to WAIT_ACK.
  - WAIT_ACK: in_ep_req = 0. On in_ep_acked go to IDLE.
- in_ep_acked is ignored in any state other than WAIT_ACK.
- ZLP rule: after a full MAX_PKT packet, with flush still pending and the FIFO empty, IDLE issues a ZLP: FILL → DONE with zero puts.
- Flush with data beyond MAX_PKT: full packets are sent first. Flush stays pending until a short packet or ZLP terminates the transfer.
- Application writes continue during every state, subject only to app_ready.
- A put is never issued unless grant && data_free in the same cycle. At most MAX_PKT puts occur per done.

Test Plan:
- Write bytes 0x00..0x3F, grant=1, data_free=1, ack 5 cycles after done → 64 consecutive puts with data 0x00..0x3F, then one done pulse. req is low in WAIT_ACK. Back to IDLE after ack, busy=0.
- Write 10 bytes 0xA0..0xA9, then pulse app_flush → 10 puts, done, flush_pending cleared. After ack, no further req.
- Write 64 bytes, pulse app_flush → 64-byte packet and ack, then ZLP (done with zero puts), ack, IDLE, no further req.
- app_flush with empty FIFO → single ZLP: req, done after grant, zero puts.
- DEPTH=128, no grant, write 130 bytes → app_ready drops once count=128 and 128 bytes are accepted. Then toggle grant/data_free pseudo-randomly → puts only when both are high, byte order preserved, two full packets.
- Assert reset_n low mid-FILL after 20 puts → all outputs 0 and app_ready=1 immediately (asynchronously). After release, new data starts a fresh packet with correct bytes.
